commit_unit: RTL

In-order retirement engine for the out-of-order MIPS core. It holds the active-list control state (head and tail pointers with colour bits, per-entry ready/type/reclaim fields) and retires at most one instruction per cycle from the oldest slot. It returns the retiring instruction's old physical register to the free list and produces the `branch_done`, `load_done` and `store_done` pulses plus the commit pointers that the state-update logic uses to release branch, load-queue and store-queue entries. Stores retire through a request/acknowledge handshake with the store-drain path.

---
 rtl/commit_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement engine for the active list. Keeps head/tail
// with colour bits, retires one ready instruction per cycle, drains stores by handshake.
module commit_unit #(
  parameter int ACTIVE_SIZE = 32,
  parameter int PHYS_W      = 6,
  parameter int BR_SIZE     = 4,
  parameter int LQ_SIZE     = 8,
  parameter int SQ_SIZE     = 8,
  parameter int FREE_SIZE   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic                             alloc_is_load,
  input  logic                             alloc_is_store,
  input  logic                             alloc_is_branch,
  input  logic                             alloc_uses_rw,
  input  logic [PHYS_W-1:0]                alloc_reclaim,
  output logic [$clog2(ACTIVE_SIZE)-1:0]   alloc_id,
  input  logic                             done_valid,
  input  logic [$clog2(ACTIVE_SIZE)-1:0]   done_id,
  input  logic                             flush_valid,
  input  logic [$clog2(ACTIVE_SIZE):0]     flush_tail,
  output logic                             store_req,
  input  logic                             store_ack,
  output logic                             commit_valid,
  output logic [$clog2(ACTIVE_SIZE)-1:0]   commit_id,
  output logic                             branch_done,
  output logic                             load_done,
  output logic                             store_done,
  output logic                             free_valid,
  output logic [PHYS_W-1:0]                free_reg,
  output logic [$clog2(BR_SIZE)-1:0]       branch_read_pointer,
  output logic [$clog2(LQ_SIZE)-1:0]       load_commit_pointer,
  output logic [$clog2(SQ_SIZE)-1:0]       store_commit_pointer,
  output logic [$clog2(FREE_SIZE)-1:0]     free_tail_pointer,
  output logic [$clog2(ACTIVE_SIZE)-1:0]   oldest_inst_pointer,
  output logic [$clog2(ACTIVE_SIZE):0]     count,
  output logic                             full,
  output logic                             empty
);

  localparam int A  = $clog2(ACTIVE_SIZE);
  localparam int BW = $clog2(BR_SIZE);
  localparam int LW = $clog2(LQ_SIZE);
  localparam int SW = $clog2(SQ_SIZE);
  localparam int FW = $clog2(FREE_SIZE);

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    STORE_WAIT = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [A:0]             head_r;
  logic [A:0]             tail_r;
  logic [A-1:0]           head_idx_s;
  logic [ACTIVE_SIZE-1:0] ready_r;
  logic [ACTIVE_SIZE-1:0] is_load_r;
  logic [ACTIVE_SIZE-1:0] is_store_r;
  logic [ACTIVE_SIZE-1:0] is_branch_r;
  logic [ACTIVE_SIZE-1:0] uses_rw_r;
  logic [PHYS_W-1:0]      reclaim_r [ACTIVE_SIZE];
  logic                   full_s;
  logic                   empty_s;
  logic                   alloc_fire_s;
  logic                   retire_s;
  logic                   store_req_r;
  logic                   commit_valid_r;
  logic                   branch_done_r;
  logic                   load_done_r;
  logic                   store_done_r;
  logic                   free_valid_r;
  logic [A-1:0]           commit_id_r;
  logic [PHYS_W-1:0]      free_reg_r;
  logic [BW-1:0]          br_ptr_r;
  logic [LW-1:0]          ld_ptr_r;
  logic [SW-1:0]          st_ptr_r;
  logic [FW-1:0]          free_ptr_r;

  assign head_idx_s   = head_r[A-1:0];
  assign empty_s      = (head_r == tail_r);
  assign full_s       = (head_r[A-1:0] == tail_r[A-1:0]) && (head_r[A] != tail_r[A]);
  assign alloc_fire_s = alloc_valid && !full_s && !flush_valid;

  // Retire decision: ready is read from registered state, stores wait for the drain ack.
  always_comb begin
    state_nxt_s = state_r;
    retire_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (!empty_s && ready_r[head_idx_s]) begin
          if (is_store_r[head_idx_s]) begin
            state_nxt_s = STORE_WAIT;
          end else begin
            retire_s = 1'b1;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      STORE_WAIT: begin
        if (store_ack) begin
          retire_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = STORE_WAIT;
        end
      end
      default: begin
        state_nxt_s = RUN;
        retire_s    = 1'b0;
      end
    endcase
  end

  // FSM state and the store request that mirrors the waiting state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      store_req_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      store_req_r <= (state_nxt_s == STORE_WAIT);
    end
  end

  // Tail pointer: a flush overrides any allocation in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_r <= {(A+1){1'b0}};
    end else if (flush_valid) begin
      tail_r <= flush_tail;
    end else if (alloc_fire_s) begin
      tail_r <= tail_r + (A+1)'(1);
    end else begin
      tail_r <= tail_r;
    end
  end

  // Per-entry fields; allocation clearing ready wins over a stale completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r     <= {ACTIVE_SIZE{1'b0}};
      is_load_r   <= {ACTIVE_SIZE{1'b0}};
      is_store_r  <= {ACTIVE_SIZE{1'b0}};
      is_branch_r <= {ACTIVE_SIZE{1'b0}};
      uses_rw_r   <= {ACTIVE_SIZE{1'b0}};
      for (int i = 0; i < ACTIVE_SIZE; i++) begin
        reclaim_r[i] <= {PHYS_W{1'b0}};
      end
    end else begin
      if (done_valid) begin
        ready_r[done_id] <= 1'b1;
      end
      if (alloc_fire_s) begin
        ready_r[tail_r[A-1:0]]     <= 1'b0;
        is_load_r[tail_r[A-1:0]]   <= alloc_is_load;
        is_store_r[tail_r[A-1:0]]  <= alloc_is_store;
        is_branch_r[tail_r[A-1:0]] <= alloc_is_branch;
        uses_rw_r[tail_r[A-1:0]]   <= alloc_uses_rw;
        reclaim_r[tail_r[A-1:0]]   <= alloc_reclaim;
      end
    end
  end

  // Head and commit-side pointers advance only on retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r     <= {(A+1){1'b0}};
      br_ptr_r   <= {BW{1'b0}};
      ld_ptr_r   <= {LW{1'b0}};
      st_ptr_r   <= {SW{1'b0}};
      free_ptr_r <= {FW{1'b0}};
    end else if (retire_s) begin
      head_r <= head_r + (A+1)'(1);
      if (is_branch_r[head_idx_s]) br_ptr_r <= br_ptr_r + BW'(1);
      if (is_load_r[head_idx_s])   ld_ptr_r <= ld_ptr_r + LW'(1);
      if (is_store_r[head_idx_s])  st_ptr_r <= st_ptr_r + SW'(1);
      if (uses_rw_r[head_idx_s])   free_ptr_r <= free_ptr_r + FW'(1);
    end else begin
      head_r <= head_r;
    end
  end

  // Registered retire pulses, visible in the cycle after the retiring edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid_r <= 1'b0;
      commit_id_r    <= {A{1'b0}};
      branch_done_r  <= 1'b0;
      load_done_r    <= 1'b0;
      store_done_r   <= 1'b0;
      free_valid_r   <= 1'b0;
      free_reg_r     <= {PHYS_W{1'b0}};
    end else begin
      commit_valid_r <= retire_s;
      branch_done_r  <= retire_s && is_branch_r[head_idx_s];
      load_done_r    <= retire_s && is_load_r[head_idx_s];
      store_done_r   <= retire_s && is_store_r[head_idx_s];
      free_valid_r   <= retire_s && uses_rw_r[head_idx_s];
      if (retire_s) begin
        commit_id_r <= head_idx_s;
        free_reg_r  <= reclaim_r[head_idx_s];
      end
    end
  end

  assign alloc_ready          = !full_s;
  assign alloc_id             = tail_r[A-1:0];
  assign store_req            = store_req_r;
  assign commit_valid         = commit_valid_r;
  assign commit_id            = commit_id_r;
  assign branch_done          = branch_done_r;
  assign load_done            = load_done_r;
  assign store_done           = store_done_r;
  assign free_valid           = free_valid_r;
  assign free_reg             = free_reg_r;
  assign branch_read_pointer  = br_ptr_r;
  assign load_commit_pointer  = ld_ptr_r;
  assign store_commit_pointer = st_ptr_r;
  assign free_tail_pointer    = free_ptr_r;
  assign oldest_inst_pointer  = head_idx_s;
  assign count                = tail_r - head_r;
  assign full                 = full_s;
  assign empty                = empty_s;

endmodule
